// File: rtl/aes_round_sequencer.sv
// Control sequencer for the byte-serial AES datapath: loads 16 plaintext bytes,
// steps NR rounds with a drain gap between rounds, then releases 16 ciphertext bytes.
module aes_round_sequencer #(
    parameter int NR       = 10,
    parameter int PERM_LAT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] byte_cnt,
    output logic [3:0] round,
    output logic       perm_clr,
    output logic       perm_en,
    output logic       sub_en,
    output logic       mix_en,
    output logic       ark_en,
    output logic       key_step,
    output logic       last_round,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_RND   = 4'(NR);
    localparam logic [4:0] DRAIN_INIT = 5'(PERM_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] byte_q, byte_d;
    logic [3:0] round_q, round_d;
    logic [4:0] drain_q, drain_d;
    logic       clr_q, clr_d;
    logic       byte_last;
    logic       round_last;

    assign byte_last  = (byte_q == 4'd15);
    assign round_last = (round_q == LAST_RND);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            byte_q  <= 4'd0;
            round_q <= 4'd0;
            drain_q <= 5'd0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            round_q <= round_d;
            drain_q <= drain_d;
            clr_q   <= clr_d;
        end
    end

    // perm_clr is registered so it appears in the cycle after start or abort,
    // keeping every output a pure decode of flops.
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        round_d = round_q;
        drain_d = drain_q;
        clr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    byte_d  = 4'd0;
                    round_d = 4'd0;
                    clr_d   = 1'b1;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    byte_d = byte_q + 4'd1;
                    if (byte_last) begin
                        state_d = S_ROUND;
                        round_d = 4'd1;
                    end
                end
            end
            S_ROUND: begin
                byte_d = byte_q + 4'd1;
                if (byte_last) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            S_DRAIN: begin
                if (drain_q == 5'd0) begin
                    if (round_last) begin
                        state_d = S_OUT;
                        byte_d  = 4'd0;
                    end else begin
                        state_d = S_ROUND;
                        round_d = round_q + 4'd1;
                    end
                end else begin
                    drain_d = drain_q - 5'd1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    byte_d = byte_q + 4'd1;
                    if (byte_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                byte_d  = 4'd0;
                round_d = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition above but is a no-op when idle.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            byte_d  = 4'd0;
            round_d = 4'd0;
            drain_d = 5'd0;
            clr_d   = 1'b1;
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        perm_en    = 1'b0;
        sub_en     = 1'b0;
        mix_en     = 1'b0;
        ark_en     = 1'b0;
        key_step   = 1'b0;
        last_round = 1'b0;
        done       = 1'b0;
        byte_cnt   = byte_q;
        round      = round_q;
        perm_clr   = clr_q;
        busy       = (state_q != S_IDLE);

        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                ark_en   = 1'b1;
            end
            S_ROUND: begin
                perm_en    = 1'b1;
                sub_en     = 1'b1;
                ark_en     = 1'b1;
                mix_en     = !round_last;
                last_round = round_last;
                key_step   = (byte_q == 4'd0);
            end
            S_OUT: begin
                out_valid = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: directed and randomized blocks
// compared cycle by cycle against a timeline model derived from handshake counts.
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_a, abort_a, in_valid_a, out_ready_a;
    logic       in_ready_a, out_valid_a, perm_clr_a, perm_en_a, sub_en_a, mix_en_a;
    logic       ark_en_a, key_step_a, last_round_a, busy_a, done_a;
    logic [3:0] byte_cnt_a, round_a;

    logic       start_b, abort_b, in_valid_b, out_ready_b;
    logic       in_ready_b, out_valid_b, perm_clr_b, perm_en_b, sub_en_b, mix_en_b;
    logic       ark_en_b, key_step_b, last_round_b, busy_b, done_b;
    logic [3:0] byte_cnt_b, round_b;

    aes_round_sequencer u_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_ready(out_ready_a), .out_valid(out_valid_a),
        .byte_cnt(byte_cnt_a), .round(round_a), .perm_clr(perm_clr_a),
        .perm_en(perm_en_a), .sub_en(sub_en_a), .mix_en(mix_en_a),
        .ark_en(ark_en_a), .key_step(key_step_a), .last_round(last_round_a),
        .busy(busy_a), .done(done_a)
    );

    aes_round_sequencer #(.NR(1), .PERM_LAT(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_ready(out_ready_b), .out_valid(out_valid_b),
        .byte_cnt(byte_cnt_b), .round(round_b), .perm_clr(perm_clr_b),
        .perm_en(perm_en_b), .sub_en(sub_en_b), .mix_en(mix_en_b),
        .ark_en(ark_en_b), .key_step(key_step_b), .last_round(last_round_b),
        .busy(busy_b), .done(done_b)
    );

    int total = 0;
    int bad   = 0;
    bit iv   [0:2047];
    bit ordy [0:2047];

    task automatic chk(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp);
        end
    endtask

    // {in_ready,out_valid,byte_cnt,round,perm_clr,perm_en,sub_en,mix_en,ark_en,key_step,last_round,busy,done}
    function automatic logic [18:0] mk(int ir, int ov, int bc, int rd, int pc, int pe, int se,
                                       int me, int ae, int ks, int lr, int bz, int dn);
        return {ir[0], ov[0], bc[3:0], rd[3:0], pc[0], pe[0], se[0], me[0], ae[0], ks[0], lr[0], bz[0], dn[0]};
    endfunction

    function automatic logic [18:0] obs(input bit w);
        if (w)
            return {in_ready_b, out_valid_b, byte_cnt_b, round_b, perm_clr_b, perm_en_b, sub_en_b,
                    mix_en_b, ark_en_b, key_step_b, last_round_b, busy_b, done_b};
        return {in_ready_a, out_valid_a, byte_cnt_a, round_a, perm_clr_a, perm_en_a, sub_en_a,
                mix_en_a, ark_en_a, key_step_a, last_round_a, busy_a, done_a};
    endfunction

    task automatic drive(input bit w, input logic st, input logic ab, input logic v, input logic r);
        if (w) begin
            start_b = st; abort_b = ab; in_valid_b = v; out_ready_b = r;
        end else begin
            start_a = st; abort_a = ab; in_valid_a = v; out_ready_a = r;
        end
    endtask

    task automatic fill_ones();
        for (int i = 0; i < 2048; i++) begin
            iv[i] = 1'b1;
            ordy[i] = 1'b1;
        end
    endtask

    // Runs one block on DUT w. Edge 0 is the edge that samples start.
    // Negative arguments disable abort, early stop, in-flight start or the fixed done-edge check.
    task automatic run_block(input bit w, input int nr, input int pl, input int abort_edge,
                             input int stop_edge, input int busy_start_edge,
                             input bit start_on_done, input int exp_done);
        int eL, eO, eD, cnt, ld_cnt, out_cnt, last_e, ks_cnt, done_e, k, r, p;
        logic [18:0] ev, o;
        string tag;
        tag = w ? "b_outputs" : "a_outputs";

        eL = -1; cnt = 0;
        for (int e = 1; e < 2000; e++) begin
            if (iv[e]) cnt++;
            if (cnt == 16) begin eL = e; break; end
        end
        eO = eL + nr * (16 + pl);
        eD = -1; cnt = 0;
        for (int e = eO + 1; e < 2000; e++) begin
            if (ordy[e]) cnt++;
            if (cnt == 16) begin eD = e; break; end
        end

        last_e = eD + (start_on_done ? 2 : 1);
        if (abort_edge >= 0) last_e = abort_edge + 1;
        if (stop_edge >= 0) last_e = stop_edge;

        drive(w, 1'b1, 1'b0, 1'b0, 1'b0);
        ld_cnt = 0; out_cnt = 0; ks_cnt = 0; done_e = -1;
        for (int e = 0; e <= last_e; e++) begin
            @(negedge clk);
            if (e >= 1 && e <= eL && iv[e]) ld_cnt++;
            if (e > eO && e <= eD && ordy[e]) out_cnt++;

            if (abort_edge >= 0 && e >= abort_edge)
                ev = mk(0, 0, 0, 0, (e == abort_edge), 0, 0, 0, 0, 0, 0, 0, 0);
            else if (e < eL)
                ev = mk(1, 0, ld_cnt, 0, (e == 0), 0, 0, 0, 1, 0, 0, 1, 0);
            else if (e < eO) begin
                k = e - eL;
                r = k / (16 + pl) + 1;
                p = k % (16 + pl);
                if (p < 16)
                    ev = mk(0, 0, p, r, 0, 1, 1, (r != nr), 1, (p == 0), (r == nr), 1, 0);
                else
                    ev = mk(0, 0, 0, r, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            end else if (e < eD)
                ev = mk(0, 1, out_cnt, nr, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            else if (e == eD)
                ev = mk(0, 0, 0, nr, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            else
                ev = 19'd0;

            o = obs(w);
            chk(tag, e, {13'd0, o}, {13'd0, ev});
            if (o[3]) ks_cnt++;
            if (done_e < 0 && o[0]) done_e = e;

            drive(w, (e + 1 == busy_start_edge) || (start_on_done && e + 1 == eD + 1),
                  (e + 1 == abort_edge), iv[e + 1], ordy[e + 1]);
        end
        drive(w, 1'b0, 1'b0, 1'b0, 1'b0);

        if (abort_edge < 0 && stop_edge < 0) begin
            chk("key_step_count", last_e, ks_cnt, nr);
            chk("done_edge", last_e, done_e, (exp_done >= 0) ? exp_done : eD);
        end
    endtask

    initial begin
        int e;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        // Reset state
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_a", 0, {13'd0, obs(0)}, 32'd0);
        chk("reset_b", 0, {13'd0, obs(1)}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_a", 0, {13'd0, obs(0)}, 32'd0);

        // Nominal block, defaults
        fill_ones();
        run_block(0, 10, 16, -1, -1, -1, 0, 352);

        // Input stalls before bytes 4 and 11
        fill_ones();
        e = 1;
        for (int b = 0; b < 16; b++) begin
            if (b == 4 || b == 11) begin
                for (int s = 0; s < 3; s++) begin iv[e] = 1'b0; e++; end
            end
            iv[e] = 1'b1;
            e++;
        end
        run_block(0, 10, 16, -1, -1, -1, 0, 358);

        // Output backpressure at byte 9
        fill_ones();
        for (int i = 346; i <= 350; i++) ordy[i] = 1'b0;
        run_block(0, 10, 16, -1, -1, -1, 0, 357);

        // Abort in round-4 drain, then a clean block
        fill_ones();
        run_block(0, 10, 16, 134, -1, -1, 0, -1);
        fill_ones();
        run_block(0, 10, 16, -1, -1, -1, 0, 352);

        // Randomized handshakes on both configurations
        for (int n = 0; n < 2; n++) begin
            fill_ones();
            for (int i = 1; i < 700; i++) begin
                iv[i]   = ($urandom_range(0, 3) != 0);
                ordy[i] = ($urandom_range(0, 3) != 0);
            end
            run_block(n[0], (n == 0) ? 10 : 1, (n == 0) ? 16 : 1, -1, -1, -1, 0, -1);
        end

        // Async reset in round 3, byte 7
        fill_ones();
        run_block(0, 10, 16, -1, 87, -1, 0, -1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_a", 87, {13'd0, obs(0)}, 32'd0);
        chk("async_reset_b", 87, {13'd0, obs(1)}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 0, {13'd0, obs(0)}, 32'd0);

        // NR=1, PERM_LAT=1 with start during busy and start on DONE
        fill_ones();
        run_block(1, 1, 1, -1, -1, 20, 1, 49);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Control FSM for the byte-serial low-area AES datapath. It accepts 16 plaintext bytes per block and streams them through NR rounds of SubBytes, byte_permutation (ShiftRows), MixColumns and AddRoundKey. It drains the permutation pipeline between rounds and then releases 16 ciphertext bytes. It owns the byte counter, round counter, stage enables and the key-schedule step strobe.

Parameters:
NR, 10, number of rounds (legal 1..14; 10/12/14 for AES-128/192/256)
PERM_LAT, 16, drain cycles after the last byte of a round before the next round starts (legal 1..31)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin a block; sampled in IDLE only
abort  in  1  synchronous abandon; returns to IDLE from any state
in_valid  in  1  plaintext byte valid
in_ready  out  1  sequencer accepts a plaintext byte
out_ready  in  1  consumer accepts a ciphertext byte
out_valid  out  1  ciphertext byte valid on the datapath output
byte_cnt  out  4  current byte index 0..15
round  out  4  current round, 0 = initial AddRoundKey
perm_clr  out  1  one-cycle clear to byte_permutation
perm_en  out  1  byte presented to byte_permutation this cycle
sub_en  out  1  SubBytes active
mix_en  out  1  MixColumns active (low in the final round)
ark_en  out  1  AddRoundKey active
key_step  out  1  advance key schedule one round key
last_round  out  1  round==NR while in ROUND
busy  out  1  state != IDLE
done  out  1  one-cycle block-complete pulse

Behaviour:
- rst low (async): state=IDLE, byte_cnt=0, round=0, drain counter=0; every output 0. Release is synchronous to clk.
- All outputs are Moore decodes of registered state and counters. There is no combinational input-to-output path.
- States: IDLE, LOAD, ROUND, DRAIN, OUT, DONE.
- IDLE:
  - All outputs 0.
  - start=1 -> LOAD, byte_cnt=0, round=0.
  - perm_clr is high for the first LOAD cycle.
- LOAD:
  - in_ready=1, ark_en=1.
  - byte_cnt increments only on in_valid&in_ready. Stall cycles (in_valid=0) hold byte_cnt.
  - Accepting byte 15 -> ROUND, round=1, byte_cnt wraps to 0.
- ROUND:
  - Exactly 16 cycles, no stalls. byte_cnt runs 0..15.
  - sub_en=perm_en=ark_en=1.
  - mix_en = (round != NR).
  - key_step=1 only when byte_cnt==0.
  - byte_cnt==15 -> DRAIN, drain counter loaded with PERM_LAT-1.
- DRAIN:
  - Enables all 0. Drain counter decrements each cycle.
  - At 0: if round==NR -> OUT, byte_cnt=0. Otherwise round+1 -> ROUND.
- OUT:
  - out_valid=1.
  - byte_cnt increments on out_valid&out_ready. out_ready=0 holds state and byte_cnt.
  - Accepting byte 15 -> DONE.
- DONE: done=1 for one cycle, busy=1 -> IDLE.
- start while busy is ignored. A start coincident with DONE is ignored; IDLE must be re-entered first.
- abort=1 in any non-IDLE state -> IDLE next edge, counters cleared, perm_clr=1 for that one cycle. abort has priority over every other transition. abort in IDLE has no effect.
- Timing with in_valid=out_ready=1 and start sampled at edge E0:
  - ROUND 1 begins after E16.
  - OUT begins after E16+NR*(16+PERM_LAT).
  - done is high between E32+NR*(16+PERM_LAT) and the following edge.
  - Defaults: done after edge 352.
- Counter wrap: byte_cnt is a 4-bit natural wrap 15->0. round never exceeds NR.

Test Plan:
1. Reset mid-ROUND: drop rst asynchronously at round=3, byte_cnt=7 -> all outputs 0 immediately, no clock needed. After release, state is IDLE, busy=0.
2. Nominal run, defaults, in_valid=out_ready=1: pulse start -> in_ready for 16 cycles, then 10 rounds each showing 16 enable cycles plus 16 drain cycles. key_step pulses exactly 10 times. mix_en=0 only in round 10. done after edge 352.
3. Input stalls: deassert in_valid on bytes 4 and 11 for 3 cycles each -> byte_cnt holds during stalls. done arrives 6 cycles later than scenario 2 (after edge 358).
4. Output backpressure: out_ready=0 for 5 cycles at byte_cnt=9 -> out_valid stays 1 and byte_cnt holds at 9. done arrives 5 cycles late.
5. Abort in DRAIN of round 4 -> next cycle busy=0, round=0, perm_clr=1 for one cycle. A following start runs a full block normally.
6. NR=1, PERM_LAT=1: pulse start -> single round with mix_en=0 and last_round=1. done after edge 49. A start asserted during busy has no effect.
